// File: rtl/sound_scheduler_pkg.sv
// sound_scheduler_pkg: shared constants, per-source sound tables and state type for the sound scheduler
package sound_scheduler_pkg;

    localparam int SOUND_NUM_SOURCES = 4;
    localparam int SOUND_SRC_W       = 2;
    localparam int SOUND_DUR_W       = 4;
    localparam int SOUND_NOTE_W      = 4;

    localparam int SOUND_SRC_ENEMY_MISSILE = 0;
    localparam int SOUND_SRC_PLAYER_HIT    = 1;
    localparam int SOUND_SRC_ASTEROID      = 2;
    localparam int SOUND_SRC_BOSS          = 3;

    typedef enum logic [1:0] {IDLE, PLAY, GAP} sound_sched_state;

    typedef logic [SOUND_NUM_SOURCES-1:0][SOUND_DUR_W-1:0]  dur_tbl_t;
    typedef logic [SOUND_NUM_SOURCES-1:0][SOUND_NOTE_W-1:0] note_tbl_t;

    // Leftmost entry is source 3, rightmost is source 0.
    localparam dur_tbl_t  SOUND_DURATION  = {4'd8, 4'd3, 4'd4, 4'd6};
    localparam note_tbl_t SOUND_BASE_NOTE = {4'd0, 4'd10, 4'd7, 4'd2};

endpackage

// File: rtl/fixed_priority_encoder.sv
// fixed_priority_encoder: reports whether any request is set and the index of the lowest set request
module fixed_priority_encoder #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_req,
    input  logic         i_unused_tie,
    output logic         o_valid,
    output logic [W-1:0] o_idx
);

    // Scan from the top down so the lowest set index is the one left standing.
    always_comb begin
        o_valid = |i_req | (i_unused_tie & 1'b0);
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--)
            if (i_req[i]) o_idx = W'(i);
    end

endmodule

// File: rtl/sound_scheduler.sv
// sound_scheduler: latches sound-event pulses and plays the highest-priority one on the single tone datapath
module sound_scheduler
    import sound_scheduler_pkg::*;
#(
    parameter int NUM_SOURCES = SOUND_NUM_SOURCES,
    parameter int SRC_W       = SOUND_SRC_W,
    parameter int DUR_W       = SOUND_DUR_W,
    parameter int NOTE_W      = SOUND_NOTE_W,
    parameter logic [NUM_SOURCES-1:0][DUR_W-1:0]  DURATION  = SOUND_DURATION,
    parameter logic [NUM_SOURCES-1:0][NOTE_W-1:0] BASE_NOTE = SOUND_BASE_NOTE
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  startOfFrame,
    input  logic [0:NUM_SOURCES-1] sound_requests,
    input  logic                  mute,
    output logic                  sound_on,
    output logic [NOTE_W-1:0]     note_idx,
    output logic [SRC_W-1:0]      cur_src,
    output logic                  busy,
    output logic [0:NUM_SOURCES-1] pending
);

    sound_sched_state         r_state, w_state_nx;
    logic [NUM_SOURCES-1:0]   r_pending, w_req, w_mask, w_pre_req, w_clr;
    logic [SRC_W-1:0]         r_cur_src, w_src_nx, w_idle_idx, w_pre_idx;
    logic [DUR_W-1:0]         r_frame_cnt, w_frame_nx;
    logic [NOTE_W-1:0]        r_note, w_note_nx;
    logic [NOTE_W:0]          w_sum;
    logic                     r_sound_on, w_idle_valid, w_pre_valid, w_last;

    // Index-true remap of the [0:N-1] ports and the mask of sources that outrank the current one.
    always_comb begin
        for (int i = 0; i < NUM_SOURCES; i++) begin
            w_req[i]   = sound_requests[i];
            pending[i] = r_pending[i];
            w_mask[i]  = i < int'(r_cur_src);
        end
    end

    assign w_pre_req = r_pending & w_mask;

    fixed_priority_encoder #(.N(NUM_SOURCES), .W(SRC_W)) u_idle_enc (
        .i_req(r_pending), .i_unused_tie(1'b0), .o_valid(w_idle_valid), .o_idx(w_idle_idx)
    );

    fixed_priority_encoder #(.N(NUM_SOURCES), .W(SRC_W)) u_pre_enc (
        .i_req(w_pre_req), .i_unused_tie(1'b0), .o_valid(w_pre_valid), .o_idx(w_pre_idx)
    );

    assign w_last    = r_frame_cnt == DURATION[r_cur_src] - DUR_W'(1);
    assign w_sum     = {1'b0, BASE_NOTE[w_src_nx]} + (NOTE_W+1)'(w_frame_nx >> 1);
    assign w_note_nx = w_sum[NOTE_W] ? '1 : w_sum[NOTE_W-1:0];

    // Next state: grant from IDLE, preempt/retrigger/advance in PLAY, leave GAP on the next frame.
    always_comb begin
        w_state_nx = r_state;
        w_src_nx   = r_cur_src;
        w_frame_nx = r_frame_cnt;
        w_clr      = '0;
        case (r_state)
            IDLE: if (w_idle_valid && !mute) begin
                w_state_nx        = PLAY;
                w_src_nx          = w_idle_idx;
                w_frame_nx        = '0;
                w_clr[w_idle_idx] = 1'b1;
            end
            PLAY: if (!mute) begin
                if (w_pre_valid) begin
                    w_src_nx         = w_pre_idx;
                    w_frame_nx       = '0;
                    w_clr[w_pre_idx] = 1'b1;
                end else if (r_pending[r_cur_src]) begin
                    w_frame_nx       = '0;
                    w_clr[r_cur_src] = 1'b1;
                end else if (startOfFrame) begin
                    if (w_last) w_state_nx = GAP;
                    else        w_frame_nx = r_frame_cnt + DUR_W'(1);
                end
            end
            GAP:  if (startOfFrame) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // Registered scheduler state; new requests win over a same-edge grant clear.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= IDLE;
            r_pending   <= '0;
            r_cur_src   <= '0;
            r_frame_cnt <= '0;
            r_note      <= '0;
            r_sound_on  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_pending   <= (r_pending & ~w_clr) | w_req;
            r_cur_src   <= w_src_nx;
            r_frame_cnt <= w_frame_nx;
            r_note      <= (w_state_nx == PLAY) ? w_note_nx : r_note;
            r_sound_on  <= (w_state_nx == PLAY) && !mute;
        end
    end

    assign sound_on = r_sound_on;
    assign note_idx = r_note;
    assign cur_src  = r_cur_src;
    assign busy     = r_state != IDLE;

endmodule

// File: tb/tb_sound_scheduler.sv
// tb_sound_scheduler: scoreboard bench for the sound scheduler
module tb_sound_scheduler;

    typedef struct { string name; logic [7:0] tup; } exp_t;
    typedef struct { string name; int sel; int want; } prb_t;

    localparam int P_SON = 0, P_BUSY = 1, P_SRC = 2, P_NOTE = 3, P_PEND = 4, P_SNOTE = 5, P_QEMPTY = 6, P_SPEND = 7;

    logic        clk = 0, resetN = 0, startOfFrame = 0, mute = 0;
    logic [0:3]  sound_requests = '0, sat_requests = '0;
    logic        sound_on, busy, s_sound_on, s_busy;
    logic [3:0]  note_idx, s_note_idx;
    logic [1:0]  cur_src, s_cur_src;
    logic [0:3]  pending, s_pending;

    exp_t        exp_q[$], sat_q[$];
    prb_t        prb_q[$];
    int          checks = 0, errors = 0;
    logic [7:0]  tup, prev_main = '0, prev_sat = '0;
    exp_t        e;
    prb_t        p;
    int          got;

    always #5 clk = ~clk;

    sound_scheduler dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .sound_requests(sound_requests),
        .mute(mute), .sound_on(sound_on), .note_idx(note_idx), .cur_src(cur_src), .busy(busy),
        .pending(pending)
    );

    sound_scheduler #(.BASE_NOTE({4'd14, 4'd10, 4'd7, 4'd2})) dut_sat (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .sound_requests(sat_requests),
        .mute(mute), .sound_on(s_sound_on), .note_idx(s_note_idx), .cur_src(s_cur_src), .busy(s_busy),
        .pending(s_pending)
    );

    function automatic int pv(input int sel);
        case (sel)
            P_SON:    return int'(sound_on);
            P_BUSY:   return int'(busy);
            P_SRC:    return int'(cur_src);
            P_NOTE:   return int'(note_idx);
            P_PEND:   return int'(pending);
            P_SNOTE:  return int'(s_note_idx);
            P_QEMPTY: return exp_q.size() + sat_q.size();
            P_SPEND:  return int'(s_pending);
            default:  return -1;
        endcase
    endfunction

    // Monitor: resolves probes and pops an expectation on every change of each DUT's output tuple.
    always @(negedge clk) begin
        while (prb_q.size() > 0) begin
            p = prb_q.pop_front();
            got = pv(p.sel);
            checks++;
            if (got != p.want) begin
                errors++;
                $display("FAIL %s: got %0d expected %0d", p.name, got, p.want);
            end
        end
        tup = {busy, sound_on, cur_src, note_idx};
        if (tup !== prev_main) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL main_unexpected: got busy/on/src/note %b/%b/%0d/%0d expected no change", tup[7], tup[6], tup[5:4], tup[3:0]);
            end else begin
                e = exp_q.pop_front();
                if (tup !== e.tup) begin
                    errors++;
                    $display("FAIL %s: got busy/on/src/note %b/%b/%0d/%0d expected %b/%b/%0d/%0d", e.name,
                             tup[7], tup[6], tup[5:4], tup[3:0], e.tup[7], e.tup[6], e.tup[5:4], e.tup[3:0]);
                end
            end
            prev_main = tup;
        end
        tup = {s_busy, s_sound_on, s_cur_src, s_note_idx};
        if (tup !== prev_sat) begin
            checks++;
            if (sat_q.size() == 0) begin
                errors++;
                $display("FAIL sat_unexpected: got busy/on/src/note %b/%b/%0d/%0d expected no change", tup[7], tup[6], tup[5:4], tup[3:0]);
            end else begin
                e = sat_q.pop_front();
                if (tup !== e.tup) begin
                    errors++;
                    $display("FAIL %s: got busy/on/src/note %b/%b/%0d/%0d expected %b/%b/%0d/%0d", e.name,
                             tup[7], tup[6], tup[5:4], tup[3:0], e.tup[7], e.tup[6], e.tup[5:4], e.tup[3:0]);
                end
            end
            prev_sat = tup;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [0:3] m);
        sound_requests = m;
        tick();
        sound_requests = '0;
    endtask

    task automatic frame();
        startOfFrame = 1;
        tick();
        startOfFrame = 0;
        tick();
        tick();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic ex(input string n, input logic b, input logic s, input logic [1:0] c, input logic [3:0] no);
        exp_q.push_back('{n, {b, s, c, no}});
    endtask

    task automatic exs(input string n, input logic b, input logic s, input logic [1:0] c, input logic [3:0] no);
        sat_q.push_back('{n, {b, s, c, no}});
    endtask

    task automatic chk(input string n, input int sel, input int want);
        prb_q.push_back('{n, sel, want});
    endtask

    initial begin
        tick(); tick();
        chk("rst_busy", P_BUSY, 0);
        chk("rst_pend", P_PEND, 0);
        tick();
        resetN = 1;
        tick(); tick();

        // Single event, source 2: base 10, 3 frames.
        ex("s2_grant", 1, 1, 2, 10); ex("s2_step", 1, 1, 2, 11); ex("s2_gap", 1, 0, 2, 11); ex("s2_idle", 0, 0, 2, 11);
        pulse(4'b0010);
        chk("lat_pend", P_PEND, 4'b0010);
        chk("lat_son_t1", P_SON, 0);
        tick();
        chk("lat_son_t2", P_SON, 1);
        chk("lat_note", P_NOTE, 10);
        chk("lat_pend_clr", P_PEND, 0);
        frames(3);
        chk("s2_gap_busy", P_BUSY, 1);
        chk("s2_gap_son", P_SON, 0);
        frame();
        chk("s2_idle_busy", P_BUSY, 0);

        // Note stepping, source 1: 7,7,8,8.
        ex("s1_grant", 1, 1, 1, 7); ex("s1_step", 1, 1, 1, 8); ex("s1_gap", 1, 0, 1, 8); ex("s1_idle", 0, 0, 1, 8);
        pulse(4'b0100);
        tick();
        frames(2);
        chk("s1_note_f2", P_NOTE, 8);
        frames(3);

        // Saturation on the second instance: base 14, 8 frames.
        exs("sat_grant", 1, 1, 3, 14); exs("sat_15", 1, 1, 3, 15); exs("sat_gap", 1, 0, 3, 15); exs("sat_idle", 0, 0, 3, 15);
        sat_requests = 4'b0001;
        tick();
        sat_requests = '0;
        tick();
        frames(8);
        chk("sat_note", P_SNOTE, 15);
        frame();

        // Preemption of source 3 by source 0 at frame 2.
        ex("p3_grant", 1, 1, 3, 0); ex("p3_f2", 1, 1, 3, 1); ex("p0_grant", 1, 1, 0, 2);
        ex("p0_f2", 1, 1, 0, 3); ex("p0_f4", 1, 1, 0, 4); ex("p0_gap", 1, 0, 0, 4); ex("p0_idle", 0, 0, 0, 4);
        pulse(4'b0001);
        tick();
        frames(2);
        pulse(4'b1000);
        chk("pre_src_t1", P_SRC, 3);
        tick();
        chk("pre_src", P_SRC, 0);
        chk("pre_note", P_NOTE, 2);
        chk("pre_pend", P_PEND, 0);
        frames(7);
        frames(3);
        chk("pre_no_replay", P_BUSY, 0);

        // Simultaneous 1 and 3: 1 plays, gap, then 3 plays.
        ex("q1_grant", 1, 1, 1, 7); ex("q1_step", 1, 1, 1, 8); ex("q1_gap", 1, 0, 1, 8); ex("q1_idle", 0, 0, 1, 8);
        ex("q3_grant", 1, 1, 3, 0); ex("q3_n1", 1, 1, 3, 1); ex("q3_n2", 1, 1, 3, 2); ex("q3_n3", 1, 1, 3, 3);
        ex("q3_gap", 1, 0, 3, 3); ex("q3_idle", 0, 0, 3, 3);
        pulse(4'b0101);
        tick();
        chk("q_pend3", P_PEND, 4'b0001);
        chk("q_src1", P_SRC, 1);
        frames(5);
        chk("q_src3", P_SRC, 3);
        chk("q_pend_clr", P_PEND, 0);
        frames(9);

        // Mute during play, unmute, then retrigger.
        ex("m_grant", 1, 1, 2, 10); ex("m_muted", 1, 0, 2, 10); ex("m_unmute", 1, 1, 2, 10); ex("m_step", 1, 1, 2, 11);
        ex("r_restart", 1, 1, 2, 10); ex("r_step", 1, 1, 2, 11); ex("r_gap", 1, 0, 2, 11); ex("r_idle", 0, 0, 2, 11);
        pulse(4'b0010);
        tick();
        frame();
        mute = 1;
        tick();
        frames(5);
        chk("mute_son", P_SON, 0);
        chk("mute_busy", P_BUSY, 1);
        chk("mute_note", P_NOTE, 10);
        mute = 0;
        tick();
        chk("unmute_son", P_SON, 1);
        frame();
        chk("unmute_note", P_NOTE, 11);
        pulse(4'b0010);
        tick();
        chk("retrig_note", P_NOTE, 10);
        frames(2);
        chk("retrig_ext", P_SON, 1);
        frames(2);

        // Muted IDLE holds the request; reset mid-play clears everything at once.
        ex("mi_grant", 1, 1, 3, 0); ex("mi_f2", 1, 1, 3, 1); ex("rst_main", 0, 0, 0, 0);
        exs("rst_sat", 0, 0, 0, 0);
        mute = 1;
        pulse(4'b0001);
        tick(); tick(); tick();
        chk("mute_idle_busy", P_BUSY, 0);
        chk("mute_idle_pend", P_PEND, 4'b0001);
        mute = 0;
        tick();
        chk("mi_son", P_SON, 1);
        chk("mi_src", P_SRC, 3);
        frames(2);
        resetN = 0;
        #2;
        chk("rst_son", P_SON, 0);
        chk("rst_busy_mid", P_BUSY, 0);
        chk("rst_note", P_NOTE, 0);
        chk("rst_src", P_SRC, 0);
        tick(); tick();
        resetN = 1;
        tick(); tick();
        chk("post_rst_busy", P_BUSY, 0);
        chk("post_rst_pend", P_PEND, 0);
        chk("sat_pend", P_SPEND, 0);
        chk("scoreboard_drained", P_QEMPTY, 0);
        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sound_scheduler.md
Name: sound_scheduler

Overview:
Arbitrates one-cycle sound-event pulses from game objects (enemy missile hit, player hit, asteroid explosion, boss death) onto the single tone datapath of the sound unit. It latches requests, grants the highest-priority pending event and plays it for a per-source number of video frames. During playback it emits a note index that steps once every two frames. It sits between the collision/event pulses and the sound unit's sine generator, and is paced by startOfFrame.

Parameters:
NUM_SOURCES, 4, number of requesters; index 0 is highest priority.
SRC_W, 2, width of source index; equals clog2(NUM_SOURCES).
DUR_W, 4, width of the frame counter; maximum duration is 2^DUR_W-1 frames.
NOTE_W, 4, width of the note index sent to the sine generator.

Ports:
clk  in  1  system clock, same domain as the video unit
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse per video frame
sound_requests  in  [0:NUM_SOURCES-1]  one-cycle event pulses; bit 0 is highest priority
mute  in  1  pause/mute; freezes playback and silences output
sound_on  out  1  tone enable to the sine generator
note_idx  out  [NOTE_W-1:0]  tone selection index
cur_src  out  [SRC_W-1:0]  source currently granted
busy  out  1  state != IDLE
pending  out  [0:NUM_SOURCES-1]  sticky latched requests (debug/verification)

Behaviour:
- Reset is asynchronous and active-low. While resetN=0: state=IDLE, pending=0, sound_on=0, note_idx=0, cur_src=0, frame_cnt=0, busy=0. Assertion mid-playback takes effect immediately.
- Pending: bit i is set on the cycle after sound_requests[i]=1. It clears on the edge where source i is granted. If set and clear coincide, set wins, so the source is re-pended.
- States: IDLE, PLAY, GAP.
- IDLE:
  - If pending != 0 and mute=0: go to PLAY next edge; cur_src = lowest-index pending bit; frame_cnt=0.
  - Latency: request pulse at cycle t gives pending at t+1 and sound_on=1 at t+2.
- PLAY:
  - sound_on = ~mute.
  - Each startOfFrame with mute=0 increments frame_cnt.
  - When frame_cnt == SOUND_DURATION[cur_src]-1 and startOfFrame=1 and mute=0: go to GAP.
- Preemption in PLAY: if any pending bit j < cur_src is set, switch next edge to cur_src=j, frame_cnt=0, and clear pending[j]. The preempted source is dropped, not re-pended.
- Retrigger: pending[cur_src] set during PLAY restarts frame_cnt=0 next edge and clears that bit. If a higher-priority source is pending on the same cycle, preemption wins.
- Lower-priority pending bits are held until the scheduler returns to IDLE.
- GAP: sound_on=0. On the next startOfFrame go to IDLE. This guarantees an audible break of at least one frame between sounds.
- note_idx = min(SOUND_BASE_NOTE[cur_src] + (frame_cnt >> 1), 2^NOTE_W-1). The add is computed one bit wider and saturated. note_idx holds its last value in IDLE/GAP.
- Mute: frame_cnt and state are frozen, except that GAP still exits. Pending bits still accumulate. No grant is made from IDLE while muted.
- Durations of 0 are illegal; a duration of 1 ends playback on the first startOfFrame.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared parameters.sv holds:
  - typedef enum sound_sched_state {IDLE, PLAY, GAP}
  - SOUND_NUM_SOURCES = 4
  - SOUND_DURATION = {6,4,3,8}
  - SOUND_BASE_NOTE = {2,7,10,0}
  - SOUND_SRC_ENEMY_MISSILE / _PLAYER_HIT / _ASTEROID / _BOSS index constants
- One sub-module: fixed_priority_encoder (valid out, lowest-set-bit index out). It is instantiated twice: once for the IDLE grant, and once masked to indices below cur_src for preemption.

Test Plan:
- Reset: resetN low mid-PLAY of src 3 -> all outputs 0 the same cycle; after release, pending=0 and state=IDLE.
- Single event: pulse req[2] at t -> pending[2]=1 at t+1; sound_on=1, cur_src=2, note_idx=10 at t+2. After 3 startOfFrame pulses -> GAP with sound_on=0; next startOfFrame -> IDLE.
- Note stepping and saturation: req[1], base 7, duration 4 -> note_idx sequence 7,7,8,8 across frames. Force base 14 with duration 8 -> note_idx saturates at 15.
- Preemption: src 3 playing at frame 2, pulse req[0] -> two edges later cur_src=0, frame_cnt=0, note_idx=2. Src 3 does not replay afterwards.
- Simultaneous and queued events: req[1] and req[3] in the same cycle -> src 1 plays for 4 frames, then GAP, then src 3 plays for 8 frames with base note 0.
- Mute and retrigger: mute=1 during PLAY -> sound_on=0, frame_cnt frozen over 5 frames. Unmute resumes the remaining frames. A second req[cur_src] pulse restarts frame_cnt at 0 and extends playback.
